// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input-conditioning block: register map and reset values.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gpio_pkg;

    // Register map, 3-bit word address
    localparam logic [2:0] ADR_GPIO    = 3'd0;   // debounced level, read-only
    localparam logic [2:0] ADR_RISE_EN = 3'd1;   // rising-edge interrupt enables
    localparam logic [2:0] ADR_FALL_EN = 3'd2;   // falling-edge interrupt enables
    localparam logic [2:0] ADR_PENDING = 3'd3;   // pending events, write-1-to-clear
    localparam logic [2:0] ADR_PERIOD  = 3'd4;   // debounce period in cycles

    // Debounce period loaded at reset
    localparam int unsigned PERIOD_RST = 16;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One-pin conditioner: 2-flop synchronizer followed by a counter-based debounce filter.
// Latency: level follows a stable pad after 2 sync cycles plus period_i+1 filter cycles.
// Backpressure: none; free-running every clock.
//
// Ports:
//   clk_i, rst_ni  - clock and synchronous active-low reset
//   pad_i          - raw asynchronous pin
//   period_i       - number of extra cycles a new value must persist before it is accepted
//   level_o        - filtered level
//   upd_o          - high on the cycle level_o will toggle at the next edge
module gpio_debounce_bit #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pad_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             level_o,
    output logic             upd_o
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = pad_i;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        upd_o   = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= period_i) begin
            // Compared with >= so a period lowered below the running count
            // takes effect on the very next differing cycle.
            level_d = sync2_q;
            cnt_d   = '0;
            upd_o   = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: debounced pins, edge-triggered pending bits and a Wishbone register slave.
// Latency: bus ack and read data one cycle after cyc&stb; pin levels per gpio_debounce_bit.
// Backpressure: single-cycle ack, no wait states; back-to-back strobes are acked every second cycle.
//
// Ports:
//   wb_clk, wb_rst_n         - clock and synchronous active-low reset
//   wb_adr_i .. wb_bte_i     - Wishbone slave inputs (cti/bte unused)
//   wb_dat_o, wb_ack_o       - registered read data and acknowledge
//   wb_err_o, wb_rty_o       - constant 0
//   pad_i                    - raw pins
//   gpio_o                   - debounced levels
//   irq_o                    - OR of pending bits
module gpio_in_cond
    import gpio_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic [2:0]    wb_adr_i,
    input  logic [7:0]    wb_dat_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [7:0]    wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    input  logic [DW-1:0] pad_i,
    output logic [DW-1:0] gpio_o,
    output logic          irq_o
);

    logic [DW-1:0]    gpio_lvl;
    logic [DW-1:0]    upd;
    logic [DW-1:0]    rise_en_q, rise_en_d;
    logic [DW-1:0]    fall_en_q, fall_en_d;
    logic [DW-1:0]    pend_q,    pend_d;
    logic [DW-1:0]    w1c;
    logic [DW-1:0]    set_ev;
    logic [CNT_W-1:0] period_q,  period_d;
    logic             ack_q,     ack_d;
    logic [7:0]       dat_q,     dat_d;
    logic [7:0]       rdata;
    logic             acc;
    logic             wr;
    logic             unused_bus;

    for (genvar i = 0; i < DW; i++) begin : g_bit
        gpio_debounce_bit #(.CNT_W(CNT_W)) u_db (
            .clk_i    (wb_clk),
            .rst_ni   (wb_rst_n),
            .pad_i    (pad_i[i]),
            .period_i (period_q),
            .level_o  (gpio_lvl[i]),
            .upd_o    (upd[i])
        );
    end

    // An access is accepted only while ack is low, which yields the
    // ack-every-other-cycle pattern for a held strobe.
    assign acc = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr  = acc & wb_we_i;

    always_comb begin
        rdata = '0;
        case (wb_adr_i)
            ADR_GPIO:    rdata = 8'(gpio_lvl);
            ADR_RISE_EN: rdata = 8'(rise_en_q);
            ADR_FALL_EN: rdata = 8'(fall_en_q);
            ADR_PENDING: rdata = 8'(pend_q);
            ADR_PERIOD:  rdata = 8'(period_q);
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        period_d  = period_q;
        w1c       = '0;
        if (wr) begin
            case (wb_adr_i)
                ADR_RISE_EN: rise_en_d = DW'(wb_dat_i);
                ADR_FALL_EN: fall_en_d = DW'(wb_dat_i);
                ADR_PENDING: w1c       = DW'(wb_dat_i);
                ADR_PERIOD:  period_d  = CNT_W'(wb_dat_i);
                default:     ;
            endcase
        end
        // upd marks the edge where the level toggles, so the current level
        // tells the direction: low now means a rising edge.
        set_ev = upd & ((~gpio_lvl & rise_en_q) | (gpio_lvl & fall_en_q));
        // OR-ing the set after the clear lets a same-cycle event win.
        pend_d = (pend_q & ~w1c) | set_ev;
        ack_d  = acc;
        dat_d  = acc ? rdata : dat_q;
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            period_q  <= CNT_W'(PERIOD_RST);
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            period_q  <= period_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign unused_bus = ^{wb_cti_i, wb_bte_i};

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;
    assign gpio_o   = gpio_lvl;
    assign irq_o    = |pend_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed bench for gpio_in_cond: register map, debounce timing, edge interrupts, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_gpio_in_cond;

    localparam int DW    = 8;
    localparam int CNT_W = 8;

    logic          wb_clk = 1'b0;
    logic          wb_rst_n;
    logic [2:0]    wb_adr_i;
    logic [7:0]    wb_dat_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [2:0]    wb_cti_i;
    logic [1:0]    wb_bte_i;
    logic [7:0]    wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          wb_rty_o;
    logic [DW-1:0] pad_i;
    logic [DW-1:0] gpio_o;
    logic          irq_o;

    int checks = 0;
    int errors = 0;

    always #5 wb_clk = ~wb_clk;

    gpio_in_cond #(.DW(DW), .CNT_W(CNT_W)) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_cti_i (wb_cti_i),
        .wb_bte_i (wb_bte_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o),
        .pad_i    (pad_i),
        .gpio_o   (gpio_o),
        .irq_o    (irq_o)
    );

    // Inputs change and outputs are sampled on the falling edge, so each
    // tick() spans exactly one rising edge.
    task automatic tick();
        @(negedge wb_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = a;    wb_dat_i = d;
        tick();
        chk("wr_ack", wb_ack_o, 1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        tick();
        chk("wr_ack_drop", wb_ack_o, 0);
    endtask

    task automatic wb_read(input logic [2:0] a, input logic [7:0] exp, input string tag);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = a;
        tick();
        chk("rd_ack", wb_ack_o, 1);
        chk(tag, wb_dat_o, exp);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] exp_rst [8];
        exp_rst = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd16, 8'd0, 8'd0, 8'd0};

        wb_rst_n = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        wb_cti_i = 3'b111; wb_bte_i = 2'b11;
        pad_i    = '0;
        repeat (3) tick();
        wb_rst_n = 1'b1;

        // Reset state and register map
        chk("rst_gpio", gpio_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_ack", wb_ack_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("err_tied", wb_err_o, 0);
        chk("rty_tied", wb_rty_o, 0);
        for (int i = 0; i < 8; i++)
            wb_read(3'(i), exp_rst[i], $sformatf("rst_rd%0d", i));
        chk("rst_irq_after_rd", irq_o, 0);

        // Held strobe: ack toggles every cycle
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 3'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("b2b_ack%0d", i), wb_ack_o, (i % 2 == 0) ? 1 : 0);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();

        // Writes to unmapped addresses are ignored
        wb_write(3'd6, 8'hA5);
        wb_read(3'd6, 8'h00, "unmapped_rd");

        // period=3: rise accepted exactly 6 edges after pad change
        wb_write(3'd4, 8'd3);
        pad_i = 8'h01;
        repeat (5) tick();
        chk("p3_edge5", gpio_o, 8'h00);
        tick();
        chk("p3_edge6", gpio_o, 8'h01);

        // 3-cycle low glitch is filtered
        pad_i = 8'h00;
        repeat (3) tick();
        pad_i = 8'h01;
        repeat (8) tick();
        chk("glitch3", gpio_o, 8'h01);

        // Edge interrupts
        pad_i = 8'h02;
        repeat (10) tick();
        chk("irq_setup_lvl", gpio_o, 8'h02);
        chk("irq_setup_none", irq_o, 0);
        wb_write(3'd1, 8'h01);
        wb_write(3'd2, 8'h02);
        pad_i = 8'h01;
        repeat (10) tick();
        chk("irq_set", irq_o, 1);
        wb_read(3'd3, 8'h03, "pend_both");
        wb_read(3'd0, 8'h01, "gpio_rd");
        wb_write(3'd3, 8'h01);
        wb_read(3'd3, 8'h02, "pend_w1c0");
        chk("irq_still", irq_o, 1);
        wb_write(3'd1, 8'h00);
        wb_write(3'd2, 8'h00);
        wb_read(3'd3, 8'h02, "pend_persist");
        chk("irq_persist", irq_o, 1);
        wb_write(3'd3, 8'h02);
        wb_read(3'd3, 8'h00, "pend_clr");
        chk("irq_clr", irq_o, 0);

        // Set beats W1C on the same edge
        pad_i = 8'h00;
        repeat (10) tick();
        chk("sw_low", gpio_o, 8'h00);
        wb_write(3'd1, 8'h01);
        pad_i = 8'h01;
        repeat (5) tick();
        chk("sw_pre", gpio_o, 8'h00);
        wb_write(3'd3, 8'h01);   // write lands on the 6th edge, with the rise
        chk("sw_lvl", gpio_o, 8'h01);
        chk("sw_irq", irq_o, 1);
        wb_read(3'd3, 8'h01, "sw_pend");
        wb_write(3'd3, 8'h01);
        wb_read(3'd3, 8'h00, "sw_clr");
        wb_write(3'd1, 8'h00);

        // period=0: 3-cycle latency
        wb_write(3'd4, 8'd0);
        pad_i = 8'h00;
        repeat (2) tick();
        chk("p0_fall_hold", gpio_o, 8'h01);
        tick();
        chk("p0_fall", gpio_o, 8'h00);
        pad_i = 8'hF0;
        repeat (2) tick();
        chk("p0_rise_hold", gpio_o, 8'h00);
        tick();
        chk("p0_rise", gpio_o, 8'hF0);

        // period 20 -> 2 while count is at 5
        wb_write(3'd4, 8'd20);
        pad_i = 8'hF1;
        repeat (7) tick();
        chk("pc_cnt5", gpio_o, 8'hF0);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 3'd4; wb_dat_i = 8'd2;
        tick();
        chk("pc_wr_ack", wb_ack_o, 1);
        chk("pc_wr_edge", gpio_o, 8'hF0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        tick();
        chk("pc_next", gpio_o, 8'hF1);

        // Reset mid-debounce and mid-ack
        wb_write(3'd2, 8'hFF);
        wb_write(3'd4, 8'd1);
        pad_i = 8'h00;
        repeat (8) tick();
        chk("mr_lvl", gpio_o, 8'h00);
        chk("mr_irq", irq_o, 1);
        wb_write(3'd4, 8'd10);
        pad_i = 8'hFF;
        repeat (5) tick();
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 3'd3;
        tick();
        chk("mr_ack", wb_ack_o, 1);
        chk("mr_dat", wb_dat_o, 8'hF1);
        wb_rst_n = 1'b0;
        tick();
        chk("mr_ack_drop", wb_ack_o, 0);
        chk("mr_dat_clr", wb_dat_o, 0);
        chk("mr_gpio_clr", gpio_o, 0);
        chk("mr_irq_clr", irq_o, 0);
        wb_rst_n = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        // Count restarts from zero with period back at 16: 2 + 17 edges
        repeat (18) tick();
        chk("mr_restart_hold", gpio_o, 8'h00);
        tick();
        chk("mr_restart_lvl", gpio_o, 8'hFF);
        wb_read(3'd1, 8'h00, "mr_rise_en");
        wb_read(3'd2, 8'h00, "mr_fall_en");
        wb_read(3'd3, 8'h00, "mr_pend");
        wb_read(3'd4, 8'd16, "mr_period");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
